// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: instruction fields,
// ALU operation codes, FSM states and instruction classes.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_NOOP    = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SLT     = 6'b101010;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_NOP = 6'b101100;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_NOOP, CL_SYSCALL, CL_ILLEGAL, CL_LW, CL_SW,
        CL_ALU, CL_XORI, CL_BNE, CL_J, CL_JR, CL_JAL
    } iclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-register, memory-handshake and datapath control bundle.
// The control unit takes the master side; the datapath takes the slave side.
interface multicycle_control_if #(
    parameter int ALUOP_W = 6,
    parameter int CNT_W   = 32
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               ir_write;
    logic               pc_write;
    logic               branch;
    logic               jump;
    logic               jump_sel;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               reg_dst;
    logic               alu_src;
    logic               wri_data_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               halted;
    logic               illegal;
    logic               bus_err;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  opcode, funct, mem_ready,
        output ir_write, pc_write, branch, jump, jump_sel, mem_read, mem_write,
               mem_to_reg, reg_write, reg_dst, alu_src, wri_data_sel, alu_op,
               halted, illegal, bus_err, instr_count
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  ir_write, pc_write, branch, jump, jump_sel, mem_read, mem_write,
               mem_to_reg, reg_write, reg_dst, alu_src, wri_data_sel, alu_op,
               halted, illegal, bus_err, instr_count
    );
endinterface

// File: rtl/multicycle_control_instr_class_decode.sv
// Combinational instruction classifier: opcode/funct to class, ALU code and
// illegal flag. ALU codes are zero-extended to ALUOP_W.
module instr_class_decode
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 6
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output iclass_t            cls,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);
    logic [5:0] code;

    always_comb begin
        cls  = CL_ILLEGAL;
        code = ALU_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_NOOP:    cls = CL_NOOP;
                    FN_SYSCALL: cls = CL_SYSCALL;
                    FN_JR:      cls = CL_JR;
                    FN_ADD:     begin cls = CL_ALU; code = ALU_ADD; end
                    FN_SUB:     begin cls = CL_ALU; code = ALU_SUB; end
                    FN_SLT:     begin cls = CL_ALU; code = ALU_SLT; end
                    default:    cls = CL_ILLEGAL;
                endcase
            end
            OP_LW:   begin cls = CL_LW;   code = ALU_ADD; end
            OP_SW:   begin cls = CL_SW;   code = ALU_ADD; end
            OP_XORI: begin cls = CL_XORI; code = ALU_XOR; end
            OP_BNE:  begin cls = CL_BNE;  code = ALU_SUB; end
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_ILLEGAL;
        endcase
    end

    assign alu_op  = ALUOP_W'(code);
    assign illegal = (cls == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with memory
// ready handshake, timeout, sticky error flags and a saturating retire counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W         = 6,
    parameter int CNT_W           = 32,
    parameter int MEM_TIMEOUT     = 16,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t             state, state_nxt;
    logic [5:0]         op_q, fn_q;
    logic [5:0]         dec_op, dec_fn;
    iclass_t            dec_cls;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_illegal;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   count_q;
    logic               illegal_q, bus_err_q;
    logic               waiting, timeout, retire, set_illegal, set_bus_err;

    // Outputs only ever see the latched fields; the live IR is classified in DECODE,
    // where every output is constant.
    assign dec_op = (state == DECODE) ? bus.opcode : op_q;
    assign dec_fn = (state == DECODE) ? bus.funct  : fn_q;

    instr_class_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode  (dec_op),
        .funct   (dec_fn),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    assign waiting = ((state == FETCH) || (state == MEM)) && !bus.mem_ready;
    // mem_ready on the limit cycle wins because waiting requires it low.
    assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LIM);

    always_comb begin
        state_nxt        = state;
        retire           = 1'b0;
        set_illegal      = 1'b0;
        set_bus_err      = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.branch       = 1'b0;
        bus.jump         = 1'b0;
        bus.jump_sel     = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.alu_src      = 1'b0;
        bus.wri_data_sel = 1'b0;
        bus.alu_op       = ALUOP_W'(ALU_NOP);
        bus.halted       = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_nxt    = DECODE;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_nxt   = HALT;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    set_illegal = 1'b1;
                    if (HALT_ON_ILLEGAL != 0) begin
                        state_nxt = HALT;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                end else if (dec_cls == CL_NOOP) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (dec_cls == CL_SYSCALL) begin
                    retire    = 1'b1;
                    state_nxt = HALT;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                bus.alu_op = dec_alu_op;
                case (dec_cls)
                    CL_LW, CL_SW: begin
                        bus.alu_src = 1'b1;
                        state_nxt   = MEM;
                    end
                    CL_ALU:  state_nxt = WB;
                    CL_XORI: begin
                        bus.alu_src = 1'b1;
                        state_nxt   = WB;
                    end
                    CL_BNE: begin
                        bus.branch = 1'b1;
                        retire     = 1'b1;
                        state_nxt  = FETCH;
                    end
                    CL_J, CL_JR, CL_JAL: begin
                        bus.jump      = 1'b1;
                        bus.pc_write  = 1'b1;
                        bus.jump_sel  = (dec_cls == CL_JR);
                        bus.reg_write = (dec_cls == CL_JAL);
                        retire        = 1'b1;
                        state_nxt     = FETCH;
                    end
                    default: state_nxt = FETCH;
                endcase
            end
            MEM: begin
                bus.mem_write = (dec_cls == CL_SW);
                bus.mem_read  = (dec_cls != CL_SW);
                if (bus.mem_ready) begin
                    if (dec_cls == CL_SW) begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_nxt   = HALT;
                end
            end
            WB: begin
                bus.reg_write    = 1'b1;
                bus.wri_data_sel = 1'b1;
                bus.mem_to_reg   = (dec_cls == CL_LW);
                bus.reg_dst      = (dec_cls != CL_LW);
                retire           = 1'b1;
                state_nxt        = FETCH;
            end
            HALT:    bus.halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            wait_cnt  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (waiting && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (set_bus_err)
                bus_err_q <= 1'b1;
            if (retire && (count_q != '1))
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.illegal     = illegal_q;
    assign bus.bus_err     = bus_err_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances differing only in
// HALT_ON_ILLEGAL, driven from the same instruction/ready stimulus.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.ALUOP_W(6), .CNT_W(32)) bus0 ();
    multicycle_control_if #(.ALUOP_W(6), .CNT_W(32)) bus1 ();

    assign bus0.opcode    = opcode;
    assign bus0.funct     = funct;
    assign bus0.mem_ready = mem_ready;
    assign bus1.opcode    = opcode;
    assign bus1.funct     = funct;
    assign bus1.mem_ready = mem_ready;

    multicycle_control #(.ALUOP_W(6), .CNT_W(32), .MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multicycle_control #(.ALUOP_W(6), .CNT_W(32), .MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Drive this cycle's inputs, then move to the falling edge to sample.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        opcode    = '0;
        funct     = '0;
        mem_ready = 1'b0;
        next();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Reset state: FETCH waiting on memory
        drive(6'b000000, 6'b000000, 1'b0);
        check("rst_mem_read", bus0.mem_read, 1);
        check("rst_ir_write", bus0.ir_write, 0);
        check("rst_halted", bus0.halted, 0);
        check("rst_illegal", bus0.illegal, 0);
        check("rst_bus_err", bus0.bus_err, 0);
        check("rst_count", bus0.instr_count, 0);
        check("rst_alu_op", bus0.alu_op, 6'b101100);
        next();

        // ADD: F D E WB, latched funct must win over a changed IR in EXEC
        drive(6'b000000, 6'b100000, 1'b1);
        check("add_ir_write", bus0.ir_write, 1);
        check("add_pc_write", bus0.pc_write, 1);
        next();
        drive(6'b000000, 6'b100000, 1'b1);
        check("add_dec_reg_write", bus0.reg_write, 0);
        check("add_dec_alu_op", bus0.alu_op, 6'b101100);
        next();
        drive(6'b000000, 6'b100010, 1'b1);
        check("add_exec_alu_op", bus0.alu_op, 6'b100000);
        check("add_exec_alu_src", bus0.alu_src, 0);
        check("add_exec_reg_write", bus0.reg_write, 0);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("add_wb_reg_write", bus0.reg_write, 1);
        check("add_wb_reg_dst", bus0.reg_dst, 1);
        check("add_wb_wds", bus0.wri_data_sel, 1);
        check("add_wb_mem_to_reg", bus0.mem_to_reg, 0);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("add_count", bus0.instr_count, 1);
        check("add_back_fetch", bus0.mem_read, 1);
        next();

        // LW with three wait cycles in MEM
        drive(6'b100011, 6'b000000, 1'b1);
        check("lw_ir_write", bus0.ir_write, 1);
        next();
        drive(6'b100011, 6'b000000, 1'b1);
        next();
        drive(6'b100011, 6'b000000, 1'b1);
        check("lw_exec_alu_op", bus0.alu_op, 6'b100000);
        check("lw_exec_alu_src", bus0.alu_src, 1);
        next();
        for (int i = 0; i < 4; i++) begin
            drive(6'b100011, 6'b000000, (i == 3));
            check($sformatf("lw_mem%0d_read", i), bus0.mem_read, 1);
            check($sformatf("lw_mem%0d_write", i), bus0.mem_write, 0);
            next();
        end
        drive(6'b100011, 6'b000000, 1'b0);
        check("lw_wb_mem_to_reg", bus0.mem_to_reg, 1);
        check("lw_wb_reg_write", bus0.reg_write, 1);
        check("lw_wb_reg_dst", bus0.reg_dst, 0);
        check("lw_wb_wds", bus0.wri_data_sel, 1);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("lw_count", bus0.instr_count, 2);
        check("lw_bus_err", bus0.bus_err, 0);
        next();

        // SW with memory stuck: 16 wait cycles then HALT with bus_err
        drive(6'b101011, 6'b000000, 1'b1);
        next();
        drive(6'b101011, 6'b000000, 1'b0);
        next();
        drive(6'b101011, 6'b000000, 1'b0);
        check("sw_exec_alu_op", bus0.alu_op, 6'b100000);
        next();
        for (int i = 0; i < 16; i++) begin
            drive(6'b101011, 6'b000000, 1'b0);
            check($sformatf("to_mem%0d_write", i), bus0.mem_write, 1);
            check($sformatf("to_mem%0d_halted", i), bus0.halted, 0);
            next();
        end
        drive(6'b101011, 6'b000000, 1'b1);
        check("to_halted", bus0.halted, 1);
        check("to_bus_err", bus0.bus_err, 1);
        check("to_mem_write", bus0.mem_write, 0);
        check("to_count", bus0.instr_count, 2);
        next();
        drive(6'b000000, 6'b000000, 1'b1);
        check("to_stays_halted", bus0.halted, 1);
        check("to_halt_ir_write", bus0.ir_write, 0);
        next();

        // mem_ready on the limit cycle wins: no timeout
        apply_reset();
        drive(6'b101011, 6'b000000, 1'b1);
        next();
        drive(6'b101011, 6'b000000, 1'b0);
        next();
        drive(6'b101011, 6'b000000, 1'b0);
        next();
        for (int i = 0; i < 16; i++) begin
            drive(6'b101011, 6'b000000, (i == 15));
            next();
        end
        drive(6'b000000, 6'b000000, 1'b0);
        check("lim_halted", bus0.halted, 0);
        check("lim_bus_err", bus0.bus_err, 0);
        check("lim_count", bus0.instr_count, 1);
        check("lim_fetch", bus0.mem_read, 1);
        next();

        // JAL then JR
        apply_reset();
        drive(6'b000011, 6'b000000, 1'b1);
        next();
        drive(6'b000011, 6'b000000, 1'b1);
        next();
        drive(6'b000011, 6'b000000, 1'b1);
        check("jal_jump", bus0.jump, 1);
        check("jal_pc_write", bus0.pc_write, 1);
        check("jal_reg_write", bus0.reg_write, 1);
        check("jal_wds", bus0.wri_data_sel, 0);
        check("jal_jump_sel", bus0.jump_sel, 0);
        next();
        drive(6'b000000, 6'b001000, 1'b1);
        next();
        drive(6'b000000, 6'b001000, 1'b1);
        next();
        drive(6'b000000, 6'b001000, 1'b1);
        check("jr_jump_sel", bus0.jump_sel, 1);
        check("jr_jump", bus0.jump, 1);
        check("jr_reg_write", bus0.reg_write, 0);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("jr_count", bus0.instr_count, 2);
        next();

        // BNE and XORI
        drive(6'b000101, 6'b000000, 1'b1);
        next();
        drive(6'b000101, 6'b000000, 1'b1);
        next();
        drive(6'b000101, 6'b000000, 1'b1);
        check("bne_branch", bus0.branch, 1);
        check("bne_alu_op", bus0.alu_op, 6'b100010);
        check("bne_pc_write", bus0.pc_write, 0);
        next();
        drive(6'b001110, 6'b000000, 1'b1);
        check("bne_count", bus0.instr_count, 3);
        next();
        drive(6'b001110, 6'b000000, 1'b1);
        next();
        drive(6'b001110, 6'b000000, 1'b1);
        check("xori_alu_op", bus0.alu_op, 6'b100110);
        check("xori_alu_src", bus0.alu_src, 1);
        next();
        drive(6'b001110, 6'b000000, 1'b0);
        check("xori_wb_reg_dst", bus0.reg_dst, 1);
        check("xori_wb_reg_write", bus0.reg_write, 1);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("xori_count", bus0.instr_count, 4);
        next();

        // Illegal opcode: NOOP path on dut0, HALT on dut1
        apply_reset();
        drive(6'b111111, 6'b000000, 1'b1);
        next();
        drive(6'b111111, 6'b000000, 1'b1);
        check("ill_dec_flag", bus0.illegal, 0);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("ill0_flag", bus0.illegal, 1);
        check("ill0_fetch", bus0.mem_read, 1);
        check("ill0_count", bus0.instr_count, 1);
        check("ill0_halted", bus0.halted, 0);
        check("ill1_flag", bus1.illegal, 1);
        check("ill1_halted", bus1.halted, 1);
        check("ill1_mem_read", bus1.mem_read, 0);
        next();
        drive(6'b000000, 6'b000000, 1'b1);
        next();
        drive(6'b000000, 6'b000000, 1'b1);
        next();
        drive(6'b000000, 6'b000000, 1'b0);
        check("noop_count", bus0.instr_count, 2);
        check("noop_illegal_sticky", bus0.illegal, 1);
        next();

        // Reset in MEM of SW aborts it; SYSCALL then halts until reset
        apply_reset();
        drive(6'b101011, 6'b000000, 1'b1);
        next();
        drive(6'b101011, 6'b000000, 1'b1);
        next();
        drive(6'b101011, 6'b000000, 1'b1);
        next();
        drive(6'b101011, 6'b000000, 1'b0);
        check("rmid_mem_write", bus0.mem_write, 1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        drive(6'b000000, 6'b000000, 1'b0);
        check("rmid_mem_write_low", bus0.mem_write, 0);
        check("rmid_count", bus0.instr_count, 0);
        check("rmid_fetch", bus0.mem_read, 1);
        next();
        drive(6'b000000, 6'b001100, 1'b1);
        next();
        drive(6'b000000, 6'b001100, 1'b1);
        next();
        for (int i = 0; i < 20; i++) begin
            drive(6'b100011, 6'b000000, 1'b1);
            check($sformatf("sys_halt%0d", i), bus0.halted, 1);
            check($sformatf("sys_halt%0d_mem_read", i), bus0.mem_read, 0);
            next();
        end
        drive(6'b000000, 6'b000000, 1'b0);
        check("sys_count", bus0.instr_count, 1);
        next();
        apply_reset();
        drive(6'b000000, 6'b000000, 1'b0);
        check("sys_reset_halted", bus0.halted, 0);
        check("sys_reset_count", bus0.instr_count, 0);
        check("sys_reset_illegal", bus1.illegal, 0);
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, with a ready handshake to memory.
- Adds a memory timeout, a HALT state for SYSCALL (no simulation exit), illegal-opcode flagging and a retired-instruction counter.
- Sits between the instruction register and the datapath muxes, regfile, ALU and memory.

Parameters:
- ALUOP_W, 6: width of alu_op; codes are zero-extended into it.
- CNT_W, 32: width of instr_count.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready; 0 disables the timeout.
- HALT_ON_ILLEGAL, 0: 1 sends an illegal opcode to HALT; 0 treats it as NOOP.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the IR; sampled in DECODE.
- funct  in  6  instruction[5:0] from the IR; sampled in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ir_write  out  1  load the IR.
- pc_write  out  1  unconditional PC load.
- branch  out  1  conditional PC load (BNE).
- jump  out  1  PC source is the jump target.
- jump_sel  out  1  0 = immediate target, 1 = register (JR).
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  writeback data comes from memory.
- reg_write  out  1  regfile write enable.
- reg_dst  out  1  destination select (1 for ADD/SUB/SLT/XORI).
- alu_src  out  1  ALU B operand is the immediate.
- wri_data_sel  out  1  0 = PC+4 (JAL), 1 = ALU/memory path.
- alu_op  out  ALUOP_W  ALU operation code.
- halted  out  1  in HALT state.
- illegal  out  1  sticky flag: an illegal instruction was decoded.
- bus_err  out  1  sticky flag: a memory timeout occurred.
- instr_count  out  CNT_W  count of retired instructions.

Behaviour:
- All outputs are Moore: a function of the state register plus the opcode/funct latched in DECODE only. No output depends combinationally on the live opcode/funct.
- Any output not listed for a state is 0. alu_op defaults to 6'b101100 (pass/nop).
- Reset: on the edge with reset=1, state goes to FETCH. illegal, bus_err, instr_count, the wait counter and latched opcode/funct clear. Reset mid-operation aborts the in-flight instruction (no retire, no count); mem_write and reg_write are low from the next cycle.
- FETCH: mem_read=1.
  - When mem_ready=1: ir_write=1, pc_write=1 (PC+4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch opcode/funct and classify.
  - NOOP (op 0, funct 0): retire, go to FETCH.
  - SYSCALL (op 0, funct 001100): retire, go to HALT.
  - Illegal: set illegal, then NOOP path or HALT per HALT_ON_ILLEGAL.
  - All other instructions: go to EXEC.
- EXEC, one cycle, per instruction:
  - LW/SW: alu_op=100000, alu_src=1, go to MEM.
  - ADD 100000, SUB 100010, SLT 101010: alu_op as listed, go to WB.
  - XORI: alu_op=100110, alu_src=1, go to WB.
  - BNE: alu_op=100010, branch=1, retire, go to FETCH.
  - J: jump=1, pc_write=1, jump_sel=0, retire, go to FETCH.
  - JR: as J but jump_sel=1.
  - JAL: as J plus reg_write=1, wri_data_sel=0.
- MEM:
  - LW: mem_read=1; on mem_ready go to WB.
  - SW: mem_write=1; on mem_ready retire and go to FETCH.
  - Otherwise hold the same outputs.
- WB, one cycle: reg_write=1.
  - LW: mem_to_reg=1, wri_data_sel=1, reg_dst=0.
  - ALU ops: reg_dst=1, wri_data_sel=1.
  - Retire, go to FETCH.
- Wait counter:
  - Increments each cycle in FETCH or MEM with mem_ready=0; clears on any state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT: set bus_err, go to HALT (the request drops).
  - mem_ready on the same cycle as the limit is reached wins: no error.
- HALT: all control outputs 0, halted=1; the block stays in HALT until reset.
- instr_count: +1 per retire; saturates at 2^CNT_W−1 (no wrap).
- Latency in cycles, with zero memory wait: NOOP 2, BNE/J/JR/JAL 3, ALU ops 4, SW 4, LW 5.

Decomposition:
- control_pkg holds:
  - opcode/funct constants (LW, SW, J, JAL, BNE, XORI, JR, ADD, SUB, SLT, SYSCALL, NOOP);
  - ALU op codes;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT; 3-bit);
  - instruction-class enum.
- One combinational sub-module, instr_class_decode: opcode/funct → class, alu_op, illegal.
- The FSM, counters and flags stay in multicycle_control.

Test Plan:
- ADD (op 0, funct 100000), mem_ready always 1 → ir_write at cycle 1; EXEC alu_op=100000; reg_write=1, reg_dst=1 at cycle 4; instr_count=1.
- LW with mem_ready low for 3 MEM cycles → mem_read held 4 cycles, WB with mem_to_reg=1, bus_err=0, total 8 cycles.
- SW with mem_ready stuck low, MEM_TIMEOUT=16 → HALT after 16 wait cycles; bus_err=1, halted=1, mem_write=0 in HALT.
- JAL then JR → JAL EXEC: jump=1, pc_write=1, reg_write=1, wri_data_sel=0; JR EXEC: jump_sel=1; count=2.
- Opcode 6'b111111 with HALT_ON_ILLEGAL=0 → illegal=1, back to FETCH after DECODE, count+1. With HALT_ON_ILLEGAL=1 → halted=1.
- Reset asserted in MEM of SW, then SYSCALL → mem_write=0 the next cycle, count=0, state FETCH; SYSCALL reaches HALT and remains there 20 cycles until reset.
